// File: rtl/apb_master_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_master_sequencer                                           |
// | Brief    : Two-requester round-robin APB master with address decode.      |
// |            Optional macro APB_PREADY_EN adds the Pready wait-state input. |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module apb_master_sequencer #(
    parameter int          NSLV     = 4,
    parameter logic [31:0] SLV_BASE = 32'h8000_0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [63:0]      req_addr,
    input  logic [1:0]       req_write,
    input  logic [63:0]      req_wdata,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [31:0]      Paddr,
    output logic [31:0]      Pwdata,
    output logic             Pwrite,
    output logic             Penable,
    output logic [NSLV-1:0]  Pselx,
    input  logic [31:0]      Prdata
`ifdef APB_PREADY_EN
    ,
    input  logic             Pready
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    // Window size kept 33 bits wide so an address below the base wraps above it.
    localparam logic [32:0] c_WIN_SIZE = 33'(NSLV) << 26;

    state_t            r_state, w_next;
    logic              r_prio;
    logic              r_id;
    logic [31:0]       r_rdata;
    logic [31:0]       r_paddr;
    logic [31:0]       r_pwdata;
    logic              r_pwrite;
    logic              r_penable;
    logic [NSLV-1:0]   r_pselx;

    logic              w_accept;
    logic              w_grant;
    logic [31:0]       w_gaddr;
    logic [32:0]       w_off;
    logic              w_in_range;
    logic [5:0]        w_idx;
    logic [NSLV-1:0]   w_sel;
    logic              w_complete;

`ifdef APB_PREADY_EN
    assign w_complete = Pready;
`else
    assign w_complete = 1'b1;
`endif

    // r_prio names the requester that wins the next two-way contention.
    assign w_grant    = (req_valid == 2'b11) ? r_prio : req_valid[1];
    assign w_accept   = (r_state == S_IDLE) && (|req_valid) && !reset;
    assign w_gaddr    = req_addr[32*w_grant +: 32];
    assign w_off      = {1'b0, w_gaddr} - {1'b0, SLV_BASE};
    assign w_in_range = (w_off < c_WIN_SIZE);
    assign w_idx      = w_off[31:26];

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (w_idx == 6'(i)) begin
                w_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (|req_valid) w_next = w_in_range ? S_SETUP : S_ERR;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_complete) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_prio    <= 1'b0;
            r_id      <= 1'b0;
            r_rdata   <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_penable <= 1'b0;
            r_pselx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_id    <= w_grant;
                r_prio  <= ~w_grant;
                r_rdata <= '0;
                // Bus-facing registers only change for a decodable address.
                if (w_in_range) begin
                    r_paddr  <= w_gaddr;
                    r_pwrite <= req_write[w_grant];
                    r_pwdata <= req_wdata[32*w_grant +: 32];
                    r_pselx  <= w_sel;
                end
            end
            if (r_state == S_SETUP) begin
                r_penable <= 1'b1;
            end
            if ((r_state == S_ACCESS) && w_complete) begin
                r_rdata   <= r_pwrite ? 32'h0 : Prdata;
                r_pselx   <= '0;
                r_penable <= 1'b0;
            end
        end
    end

    assign req_ready = w_accept ? (2'b01 << w_grant) : 2'b00;
    assign rsp_valid = (r_state == S_RESP) || (r_state == S_ERR);
    assign rsp_err   = (r_state == S_ERR);
    assign rsp_id    = r_id;
    assign rsp_rdata = r_rdata;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;
    assign Pwrite    = r_pwrite;
    assign Penable   = r_penable;
    assign Pselx     = r_pselx;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_sequencer.sv
`default_nettype none
// Self-checking bench for apb_master_sequencer: directed table, corner
// sequences, and randomized transfers against a transaction-level model.
module tb_apb_master_sequencer;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          NS   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_addr = '0;
    logic [1:0]  req_write = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pwrite;
    logic        Penable;
    logic [3:0]  Pselx;
    logic [31:0] Prdata = '0;
`ifdef APB_PREADY_EN
    logic        Pready = 1'b0;
`endif

    apb_master_sequencer #(.NSLV(NS), .SLV_BASE(BASE)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Pwrite    (Pwrite),
        .Penable   (Penable),
        .Pselx     (Pselx),
        .Prdata    (Prdata)
`ifdef APB_PREADY_EN
        ,
        .Pready    (Pready)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0, a1;
        logic [1:0]  wr;
        logic [31:0] d0, d1;
        logic [31:0] prdata;
        int          waits;
        logic        exp_grant;
        logic        exp_err;
        logic [3:0]  exp_sel;
        logic [31:0] exp_rdata;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          m_last = 1;
    logic [31:0] last_paddr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level prediction: window test and slave index by plain arithmetic.
    function automatic vec_t predict(vec_t v);
        vec_t        r;
        int          g;
        logic [31:0] a;
        longint      off;
        r = v;
        if (v.valid == 2'b11) g = 1 - m_last;
        else g = v.valid[1] ? 1 : 0;
        a   = (g == 1) ? v.a1 : v.a0;
        off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        r.exp_grant = (g == 1);
        if (off >= 0 && off < longint'(NS) * 64'h400_0000) begin
            r.exp_err   = 1'b0;
            r.exp_sel   = 4'(4'b0001 << (off / 64'h400_0000));
            r.exp_rdata = v.wr[g] ? 32'h0 : v.prdata;
        end else begin
            r.exp_err   = 1'b1;
            r.exp_sel   = 4'b0000;
            r.exp_rdata = 32'h0;
        end
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        m_last = 1;
        last_paddr = '0;
    endtask

    task automatic run_txn(input vec_t v);
        logic [31:0] ea, ed;
        logic        ew;
        int          nw;
        nw = 0;
`ifdef APB_PREADY_EN
        nw = v.waits;
`endif
        ea = v.exp_grant ? v.a1 : v.a0;
        ed = v.exp_grant ? v.d1 : v.d0;
        ew = v.wr[v.exp_grant];
        @(posedge clock); #1;
        req_valid = v.valid;
        req_addr  = {v.a1, v.a0};
        req_write = v.wr;
        req_wdata = {v.d1, v.d0};
        Prdata    = v.prdata;
        #1 chk("grant", 64'(req_ready), v.exp_grant ? 64'h2 : 64'h1);
        m_last = v.exp_grant ? 1 : 0;
        @(posedge clock); #1;
        req_valid = '0;
        #1;
        if (v.exp_err) begin
            chk("err_valid", 64'(rsp_valid), 64'h1);
            chk("err_flag",  64'(rsp_err),   64'h1);
            chk("err_rdata", 64'(rsp_rdata), 64'h0);
            chk("err_id",    64'(rsp_id),    64'(v.exp_grant));
            chk("err_psel",  64'(Pselx),     64'h0);
            chk("err_paddr_hold", 64'(Paddr), 64'(last_paddr));
        end else begin
            chk("setup_psel",  64'(Pselx),   64'(v.exp_sel));
            chk("setup_pen",   64'(Penable), 64'h0);
            chk("setup_paddr", 64'(Paddr),   64'(ea));
            chk("setup_pwr",   64'(Pwrite),  64'(ew));
            chk("setup_pwd",   64'(Pwdata),  64'(ed));
            chk("setup_busy",  64'({rsp_valid, req_ready}), 64'h0);
            for (int w = 0; w <= nw; w++) begin
                @(posedge clock); #1;
`ifdef APB_PREADY_EN
                Pready = (w == nw);
`endif
                #1;
                chk("acc_pen",   64'(Penable),   64'h1);
                chk("acc_psel",  64'(Pselx),     64'(v.exp_sel));
                chk("acc_paddr", 64'(Paddr),     64'(ea));
                chk("acc_rsp",   64'(rsp_valid), 64'h0);
            end
            @(posedge clock); #1;
`ifdef APB_PREADY_EN
            Pready = 1'b0;
`endif
            #1;
            chk("rsp_valid", 64'(rsp_valid), 64'h1);
            chk("rsp_err",   64'(rsp_err),   64'h0);
            chk("rsp_id",    64'(rsp_id),    64'(v.exp_grant));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
            chk("rsp_bus_idle", 64'({Pselx, Penable}), 64'h0);
            last_paddr = ea;
        end
        @(posedge clock); #2;
        chk("rsp_single", 64'(rsp_valid), 64'h0);
    endtask

    vec_t tbl[7];
    vec_t rv;
    int   grants[$];

    initial begin
        //          valid  a0             a1             wr     d0             d1             prdata         w  g  e  sel      rdata
        tbl[0] = '{2'b01, 32'h8400_0010, 32'h0,         2'b01, 32'hDEAD_BEEF, 32'h0,         32'h5555_0000, 0, 0, 0, 4'b0010, 32'h0};
        tbl[1] = '{2'b10, 32'h0,         32'h8C00_0004, 2'b00, 32'h0,         32'h0,         32'h1234_5678, 2, 1, 0, 4'b1000, 32'h1234_5678};
        tbl[2] = '{2'b01, 32'h0000_1000, 32'h0,         2'b00, 32'h0,         32'h0,         32'h7777_7777, 0, 0, 1, 4'b0000, 32'h0};
        tbl[3] = '{2'b11, 32'h8000_0000, 32'h8FFF_FFFC, 2'b10, 32'h1111_1111, 32'h0BAD_F00D, 32'h9999_9999, 0, 1, 0, 4'b1000, 32'h0};
        tbl[4] = '{2'b11, 32'h9000_0000, 32'h8000_0004, 2'b01, 32'h2222_2222, 32'h0,         32'h0,         0, 0, 1, 4'b0000, 32'h0};
        tbl[5] = '{2'b10, 32'h0,         32'h7FFF_FFFC, 2'b00, 32'h0,         32'h0,         32'h3333_3333, 0, 1, 1, 4'b0000, 32'h0};
        tbl[6] = '{2'b11, 32'h8800_0000, 32'h8400_0000, 2'b00, 32'h0,         32'h0,         32'hA5A5_5A5A, 1, 0, 0, 4'b0100, 32'hA5A5_5A5A};

        // Outputs while reset is held.
        #2;
        chk("rst_outs", {30'h0, req_ready, rsp_valid, rsp_id, rsp_err, Penable, Pwrite, Pselx, 24'h0},
            64'h0);
        chk("rst_paddr", {Paddr, Pwdata}, 64'h0);
        chk("rst_rdata", 64'(rsp_rdata), 64'h0);
        do_reset();

        // Sustained two-way contention from reset.
        req_addr  = {32'h8400_0100, 32'h8000_0100};
        req_write = 2'b00;
        Prdata    = 32'h0F0F_0F0F;
        @(posedge clock); #1 req_valid = 2'b11;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                chk("ready_onehot", 64'($onehot(req_ready)), 64'h1);
                grants.push_back(req_ready[1] ? 1 : 0);
            end
            @(posedge clock); #1;
        end
        req_valid = 2'b00;
        if (grants.size() != 4) chk("contention_timeout", 64'(grants.size()), 64'h4);
        for (int k = 0; k < grants.size(); k++) chk("rr_order", 64'(grants[k]), 64'(k % 2));
        repeat (5) @(posedge clock);

        do_reset();
        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset in the middle of ACCESS.
        @(posedge clock); #1;
        req_valid = 2'b01; req_addr = {32'h0, 32'h8400_0020};
        req_write = 2'b01; req_wdata = {32'h0, 32'hCAFE_F00D};
        @(posedge clock); #1 req_valid = 2'b00;
        @(posedge clock); #2;
        chk("pre_rst_access", 64'({Penable, Pwrite}), 64'h3);
        req_valid = 2'b11;
        reset = 1'b1;
        #1;
        chk("mid_rst_ctrl", 64'({req_ready, rsp_valid, rsp_err, rsp_id, Penable, Pwrite, Pselx}), 64'h0);
        chk("mid_rst_data", {Paddr, Pwdata}, 64'h0);
        chk("mid_rst_rdata", 64'(rsp_rdata), 64'h0);
        @(posedge clock); #1;
        req_valid = 2'b00;
        reset = 1'b0;
        m_last = 1;
        last_paddr = '0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #2;
            chk("dropped_no_rsp", 64'(rsp_valid), 64'h0);
        end
        rv = '{2'b11, 32'h8000_0040, 32'h8400_0040, 2'b00, 32'h0, 32'h0, 32'h600D_600D, 0, 0, 0, 4'b0001, 32'h600D_600D};
        run_txn(rv);

        // Randomized transfers against the model.
        for (int n = 0; n < 40; n++) begin
            rv.valid = 2'($urandom_range(1, 3));
            rv.a0 = ($urandom_range(0, 4) == 0) ? $urandom() : (BASE + ($urandom_range(0, 32'h0FFF_FFFF) & 32'hFFFF_FFFC));
            rv.a1 = ($urandom_range(0, 4) == 0) ? $urandom() : (BASE + ($urandom_range(0, 32'h0FFF_FFFF) & 32'hFFFF_FFFC));
            rv.wr = 2'($urandom_range(0, 3));
            rv.d0 = $urandom();
            rv.d1 = $urandom();
            rv.prdata = $urandom();
            rv.waits = $urandom_range(0, 2);
            rv = predict(rv);
            run_txn(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
